fma_issue_ctrl: RTL
===================

FMA_ISSUE_CTRL -- requirements
Module: fma_issue_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- BW_FP, 17, FP operand width.
- LANES, 64, FMA lanes driven.
- FMA_LAT, 4, cycles from operands on a_out/b_out/c_out to the matching result on FMA_out; legal range 1..8.
- OBUF_DEPTH, 4, result FIFO entries; must be at least 2.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that opens a job.
- in_valid, in, 1, operand beat valid.
- in_ready, out, 1, operand beat accepted.
- in_mode, in, 5, FMA op code, broadcast to all lanes.
- in_a, in, LANES*BW_FP, lane operand a.
- in_b, in, LANES*BW_FP, lane operand b.
- in_c, in, LANES*BW_FP, lane operand c.
- in_last, in, 1, final beat of the job.
- busy, out, 1, arbitration request to the FMA array owner.
- mode_out, out, LANES*5, per-lane op code.
- a_out, out, LANES*BW_FP, lane operand a to the FMA array.
- b_out, out, LANES*BW_FP, lane operand b to the FMA array.
- c_out, out, LANES*BW_FP, lane operand c to the FMA array.
- FMA_out, in, LANES*BW_FP, FMA array results.
- out_valid, out, 1, result beat valid.
- out_ready, in, 1, downstream accepts the result beat.
- out_data, out, LANES*BW_FP, result beat.
- out_last, out, 1, final result of the job.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-004 IDLE SHALL go to RUN on start; start SHALL be ignored in RUN and DRAIN.
REQ-005 RUN SHALL go to DRAIN in the cycle after a beat with in_last=1 is accepted.
REQ-006 DRAIN SHALL go to IDLE once no beats are in flight and the FIFO is empty after the out_last beat has been accepted.
REQ-007 busy SHALL be registered and equal 1 exactly when the state is RUN or DRAIN.
REQ-008 in_ready SHALL equal 1 only in RUN, and only when in_flight + fifo_count + 1 <= OBUF_DEPTH (credit rule); in_ready SHALL NOT depend combinationally on in_valid.
REQ-009 An accepted beat SHALL drive, on the next cycle only, mode_out = in_mode replicated into all LANES 5-bit fields and a_out/b_out/c_out = in_a/in_b/in_c.
REQ-010 In any cycle that follows a cycle with no accept, mode_out, a_out, b_out and c_out SHALL be all zero (NOP).
REQ-011 A valid bit and a last tag SHALL travel through an FMA_LAT-deep shift register.
REQ-012 When the valid bit exits the shift register, FMA_out SHALL be written to the FIFO together with the last tag, in the same cycle.
REQ-013 The FIFO SHALL never overflow; the credit rule guarantees this. An overflowing write SHALL raise a sticky internal error flag for simulation assertions.
REQ-014 out_valid SHALL be 1 whenever the FIFO is not empty.
REQ-015 out_data and out_last SHALL come from the FIFO head and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 The FIFO SHALL pop on out_valid && out_ready. A simultaneous push and pop SHALL leave the count unchanged, and the read and write pointers SHALL wrap modulo OBUF_DEPTH.
REQ-017 A push into an empty FIFO SHALL be visible on out_valid in the next cycle; there is no bypass.
REQ-018 in_flight SHALL count entries in the shift register. It SHALL increment on accept, decrement on exit, and stay unchanged when both happen in the same cycle.
REQ-019 Total latency from an accept at cycle t to out_valid SHALL be t+1+FMA_LAT+1 when the FIFO is empty.
REQ-020 Beats SHALL exit the block in acceptance order; no reordering.
REQ-021 A job with a single beat (in_last on the first beat) SHALL work identically to a longer job.
REQ-022 in_valid outside RUN SHALL be ignored and SHALL not be accepted.

Reset
REQ-023 On rst_n=0 the block SHALL asynchronously force:
- state to IDLE;
- busy, in_ready, out_valid and out_last to 0;
- mode_out, a_out, b_out, c_out and out_data to 0;
- FIFO pointers, FIFO count, in_flight, the shift register and the error flag to 0.
REQ-024 A reset mid-job SHALL discard all in-flight and buffered results. The block SHALL accept a new start on the first clock edge after rst_n rises.

Verification
REQ-025 Single beat, FMA_LAT=4, out_ready=1: start, then one beat with in_mode=5'h03, all a lanes 17'h0F800, in_last=1.
- Expected: mode_out = 64 copies of 5'h03 for exactly one cycle.
- Expected: out_valid rises 6 cycles after the accept and out_last=1.
- Expected: busy drops in the cycle after the pop.
REQ-026 Credit stall: 8 back-to-back beats with out_ready=0.
- Expected: exactly 4 beats are accepted, then in_ready stays 0 and the FIFO holds 4 entries with no overflow.
- Expected: after out_ready is raised, the remaining 4 beats complete in order.
REQ-027 Backpressure stability: toggle out_ready 1010...
- Expected: out_data holds while out_valid=1 and out_ready=0.
- Expected: the FIFO count is unchanged in cycles with a simultaneous push and pop.
REQ-028 Ordering: 16 beats with lane-0 tag values 1..16 through an echo FMA model (z=a).
- Expected: out_data lane 0 yields 1..16, with out_last only on 16.
REQ-029 Reset mid-job: assert rst_n=0 with 3 beats in flight.
- Expected: all outputs are 0 immediately.
- Expected: a new single-beat job after release completes correctly, with no stale results.
REQ-030 Ignored inputs: in_valid=1 while IDLE, and start while RUN.
- Expected: in_ready stays 0 in IDLE, and the job state is unchanged.

Source files
------------

// File: rtl/fma_issue_ctrl.sv
// Issue controller for a LANES-wide FMA array: credit-gated operand issue,
// latency-matched valid/last tracking and an in-order result FIFO.
module fma_issue_ctrl #(
    parameter int unsigned BW_FP      = 17,
    parameter int unsigned LANES      = 64,
    parameter int unsigned FMA_LAT    = 4,
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_mode,
    input  logic [LANES*BW_FP-1:0] in_a,
    input  logic [LANES*BW_FP-1:0] in_b,
    input  logic [LANES*BW_FP-1:0] in_c,
    input  logic                   in_last,
    output logic                   busy,
    output logic [LANES*5-1:0]     mode_out,
    output logic [LANES*BW_FP-1:0] a_out,
    output logic [LANES*BW_FP-1:0] b_out,
    output logic [LANES*BW_FP-1:0] c_out,
    input  logic [LANES*BW_FP-1:0] FMA_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*BW_FP-1:0] out_data,
    output logic                   out_last
);

    localparam int unsigned DW = LANES * BW_FP;
    localparam int unsigned PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned FW = $clog2(FMA_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state, state_next;
    logic           acc_c, exit_c, push_c, pop_c, credit_c;
    logic [FW-1:0]  in_flight, in_flight_next;
    logic [CW-1:0]  fifo_count, fifo_count_next;
    logic [PW-1:0]  rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
    logic           v_iss, last_iss;
    logic [FMA_LAT-1:0] sr_v, sr_last;
    logic [DW-1:0]  mem [OBUF_DEPTH];
    logic           mem_last [OBUF_DEPTH];
    logic           ovf_err;

    assign acc_c  = in_valid && in_ready && (state == RUN);
    assign exit_c = sr_v[FMA_LAT-1];
    assign push_c = exit_c;
    assign pop_c  = out_valid && out_ready;

    // Next state, occupancy counters and FIFO pointers
    always_comb begin
        state_next      = state;
        in_flight_next  = in_flight;
        fifo_count_next = fifo_count;
        rd_ptr_next     = rd_ptr;
        wr_ptr_next     = wr_ptr;
        if (acc_c && !exit_c)      in_flight_next = in_flight + FW'(1);
        else if (!acc_c && exit_c) in_flight_next = in_flight - FW'(1);
        if (push_c && !pop_c)      fifo_count_next = fifo_count + CW'(1);
        else if (!push_c && pop_c) fifo_count_next = fifo_count - CW'(1);
        if (pop_c)  rd_ptr_next = (rd_ptr == PW'(OBUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        if (push_c) wr_ptr_next = (wr_ptr == PW'(OBUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (acc_c && in_last) state_next = DRAIN;
            DRAIN:   if (pop_c && out_last && in_flight_next == '0 && fifo_count_next == '0)
                         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new beat fits only if every outstanding result still has a FIFO slot
    assign credit_c = (32'(in_flight_next) + 32'(fifo_count_next) + 32'd1) <= OBUF_DEPTH;

    // State, handshake, operand issue and latency-matching shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            in_flight <= '0;
            mode_out  <= '0;
            a_out     <= '0;
            b_out     <= '0;
            c_out     <= '0;
            v_iss     <= 1'b0;
            last_iss  <= 1'b0;
            sr_v      <= '0;
            sr_last   <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            in_ready  <= (state_next == RUN) && credit_c;
            in_flight <= in_flight_next;
            mode_out  <= acc_c ? {LANES{in_mode}} : '0;
            a_out     <= acc_c ? in_a : '0;
            b_out     <= acc_c ? in_b : '0;
            c_out     <= acc_c ? in_c : '0;
            v_iss     <= acc_c;
            last_iss  <= acc_c && in_last;
            sr_v[0]   <= v_iss;
            sr_last[0] <= last_iss;
            for (int i = 1; i < int'(FMA_LAT); i++) begin
                sr_v[i]    <= sr_v[i-1];
                sr_last[i] <= sr_last[i-1];
            end
        end
    end

    // Result FIFO with a registered head; a push into an empty FIFO lands directly in the head register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                mem[i]      <= '0;
                mem_last[i] <= 1'b0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr]      <= FMA_out;
                mem_last[wr_ptr] <= sr_last[FMA_LAT-1];
            end
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            fifo_count <= fifo_count_next;
            out_valid  <= (fifo_count_next != '0);
            if (push_c && (wr_ptr == rd_ptr_next)) begin
                out_data <= FMA_out;
                out_last <= sr_last[FMA_LAT-1];
            end else begin
                out_data <= mem[rd_ptr_next];
                out_last <= mem_last[rd_ptr_next];
            end
            if (push_c && !pop_c && (fifo_count == CW'(OBUF_DEPTH)))
                ovf_err <= 1'b1;
        end
    end

    // The credit rule must make overflow unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !ovf_err);

endmodule
